alu_arbiter: RTL
================

# alu_arbiter

Shares one `alu` instance between two requesters using round-robin arbitration with a valid/ready handshake. It adds an optional lock so a requester can issue MUL/DIV and its following MFHI without the other requester overwriting `hi` in between. It sits between two issue sources (e.g. the core datapath and a coprocessor/debug port) and the ALU's `x`/`y`/`mode` inputs and `z` output. Operations are pipelined, one issue per cycle.

## Interface
- `N`, 32: operand/result width; must match the ALU's `N`.
- `LOCK_MAX`, 16: cycles without an owner handshake before a lock is forcibly released; ≥1.

- `clk` in 1: single clock; the ALU shares it.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: request present.
- `req0_ready` / `req1_ready` out 1: grant; handshake when valid && ready at a `clk` rising edge.
- `req0_x` / `req1_x`, `req0_y` / `req1_y` in N: operands.
- `req0_mode` / `req1_mode` in 4: ALU opcode, forwarded verbatim.
- `req0_lock` / `req1_lock` in 1: request `hi` lock; only meaningful with MUL (0011) or DIV (0100).
- `resp0_valid` / `resp1_valid` out 1: one-cycle pulse; result for that requester is on `resp_z`.
- `resp_z` out N: combinational pass-through of `alu_z`.
- `lock_owner` out 2: 00 none, 01 req0, 10 req1.
- `lock_expired` out 1: one-cycle pulse when a lock times out.
- `alu_x`, `alu_y` out N, `alu_mode` out 4: registered drive to the ALU.
- `alu_z` in N: ALU result.

## Operation
- Grant is combinational from the valid inputs and the registered state. Valid must not depend on ready.
  - Unlocked, one requester valid: that requester is ready.
  - Unlocked, both valid: the requester selected by `rr_ptr` is ready.
  - Locked: only the owner can be ready; the other requester's ready is 0.
- `rr_ptr` resets to 0. After any handshake it points to the other requester. It is not updated while nothing is granted.
- On a handshake, the winner's x/y/mode are registered into `alu_x`/`alu_y`/`alu_mode`. With no handshake, `alu_mode` is 0000 (ALU NOP, `z` holds). Modes 0000 and 1100 are accepted and forwarded; the response carries the unchanged `z`.
- A 1-deep response pipeline holds {valid, id}. `respN_valid` is raised for the issuing requester one cycle after `alu_mode` carries its op.
- Lock FSM states:
  - UNLOCKED → LOCK0/LOCK1 on a handshake with lock=1 and mode 0011 or 0100.
  - LOCKi → UNLOCKED on owner handshake with mode 1101 (MFHI). The MFHI itself is issued.
  - LOCKi → UNLOCKED on timeout.
  - LOCKi stays LOCKi on any other owner handshake, including a new locked MUL/DIV.
- Timeout counter (width clog2(LOCK_MAX+1)):
  - Clears on entering LOCKi and on every owner handshake.
  - Otherwise increments each LOCKi cycle.
  - When it reaches LOCK_MAX: state → UNLOCKED, `lock_expired` pulses for that one cycle, counter clears.
- `lock_owner` is decoded from the FSM state.

## Timing
- Handshake at edge k → `alu_mode`/`alu_x`/`alu_y` valid after k → ALU registers `z` at k+1 → `respi_valid` = 1 and `resp_z` = result during the cycle between k+1 and k+2. Latency is 2 edges; throughput is 1 op/cycle.
- Back-to-back: responses return in issue order, one per cycle, with no bubbles.
- Lock release by MFHI at edge k: the other requester can be granted in the cycle after k. `rr_ptr` already points to it.
- Timeout at edge k: the other requester can be granted in the cycle after k. The owner then competes normally.
- Reset, all after the `rst` edge: `req*_ready` = 0, `resp*_valid` = 0, `alu_x` = `alu_y` = 0, `alu_mode` = 0000, `lock_owner` = 00, `lock_expired` = 0, `rr_ptr` = 0, counter = 0. The ALU is not reset, so `hi`/`z` contents are undefined until written.
- Reset mid-operation: in-flight responses are discarded (no `resp*_valid`) and any lock is dropped.
- Simultaneous lock release and request: the release handshake and the new grant never occur in the same cycle. The other requester waits at least one cycle.

## Test plan
- Single op:
  - Stimulus: after reset, req0 ADD x=5 y=3.
  - Response: `req0_ready` = 1 in the same cycle; `alu_mode` = 0001 after the edge; `resp0_valid` pulse two edges after the handshake with `resp_z` = 8; `resp1_valid` stays 0.
- Round-robin:
  - Stimulus: both requesters continuously valid (req0 ADD 1+1, req1 SUB 9-4) for 6 cycles.
  - Response: grants alternate 0,1,0,1,0,1; responses alternate 2,5,2,5,2,5 on the matching `resp*_valid`.
- Lock:
  - Stimulus: req0 locked MUL x=0x10000 y=0x10000 (N=32); req1 valid throughout; req0 then issues MFHI 3 cycles later.
  - Response: `lock_owner` = 01; `req1_ready` = 0 until the MFHI handshake; MUL `resp_z` = 0; MFHI `resp_z` = 1; req1 is granted the next cycle.
- Timeout:
  - Stimulus: LOCK_MAX=4; req1 locked DIV x=7 y=2, then req1 idle; req0 valid throughout.
  - Response: DIV `resp_z` = 3; `lock_expired` pulses 4 cycles after the handshake; `lock_owner` → 00; req0 is granted the following cycle.
- Pipelined DIV/MFHI:
  - Stimulus: req0 locked DIV 7/2 and MFHI on consecutive cycles.
  - Response: `resp0_valid` on 2 consecutive cycles with `resp_z` = 3 then 1.
- Reset mid-op:
  - Stimulus: assert `rst` the cycle after a locked MUL handshake.
  - Response: no `resp*_valid`; `alu_mode` = 0000; `lock_owner` = 00; after `rst` is released, req1 is granted immediately.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with an
// optional hi-register lock held from MUL/DIV until the owner's MFHI.
module alu_arbiter #(
  parameter int N        = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_x,
  input  logic [N-1:0] req0_y,
  input  logic [3:0]   req0_mode,
  input  logic         req0_lock,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_x,
  input  logic [N-1:0] req1_y,
  input  logic [3:0]   req1_mode,
  input  logic         req1_lock,
  output logic         resp0_valid,
  output logic         resp1_valid,
  output logic [N-1:0] resp_z,
  output logic [1:0]   lock_owner,
  output logic         lock_expired,
  output logic [N-1:0] alu_x,
  output logic [N-1:0] alu_y,
  output logic [3:0]   alu_mode,
  input  logic [N-1:0] alu_z
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  localparam logic [3:0] MODE_NOP  = 4'b0000;
  localparam logic [3:0] MODE_MUL  = 4'b0011;
  localparam logic [3:0] MODE_DIV  = 4'b0100;
  localparam logic [3:0] MODE_MFHI = 4'b1101;

  typedef enum logic [1:0] {
    UNLOCKED = 2'b00,
    LOCK0    = 2'b01,
    LOCK1    = 2'b10
  } lock_state_t;

  lock_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          expired_next;
  logic          rr_ptr;
  logic          grant0, grant1, hs, win;
  logic [N-1:0]  win_x, win_y;
  logic [3:0]    win_mode;
  logic          win_lock;
  logic          issue_valid, issue_id;
  logic          resp_valid, resp_id;

  // Grant is purely combinational; nothing is granted while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      unique case (state)
        LOCK0: grant0 = req0_valid;
        LOCK1: grant1 = req1_valid;
        default: begin
          grant0 = req0_valid && (!req1_valid || !rr_ptr);
          grant1 = req1_valid && (!req0_valid ||  rr_ptr);
        end
      endcase
    end
  end

  assign hs       = grant0 | grant1;
  assign win      = grant1;
  assign win_x    = win ? req1_x    : req0_x;
  assign win_y    = win ? req1_y    : req0_y;
  assign win_mode = win ? req1_mode : req0_mode;
  assign win_lock = win ? req1_lock : req0_lock;

  // While locked only the owner can handshake, so hs implies an owner handshake.
  // The timeout fires on the edge completing LOCK_MAX idle cycles, so the
  // counter clears instead of ever holding LOCK_MAX.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    expired_next = 1'b0;
    unique case (state)
      UNLOCKED: begin
        if (hs && win_lock && (win_mode == MODE_MUL || win_mode == MODE_DIV)) begin
          state_next = win ? LOCK1 : LOCK0;
          cnt_next   = '0;
        end
      end
      LOCK0, LOCK1: begin
        if (hs) begin
          cnt_next = '0;
          if (win_mode == MODE_MFHI) state_next = UNLOCKED;
        end else if (cnt == CW'(LOCK_MAX - 1)) begin
          state_next   = UNLOCKED;
          cnt_next     = '0;
          expired_next = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = UNLOCKED;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= UNLOCKED;
      cnt          <= '0;
      lock_expired <= 1'b0;
      rr_ptr       <= 1'b0;
      alu_x        <= '0;
      alu_y        <= '0;
      alu_mode     <= MODE_NOP;
      issue_valid  <= 1'b0;
      issue_id     <= 1'b0;
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      lock_expired <= expired_next;
      if (hs) begin
        alu_x    <= win_x;
        alu_y    <= win_y;
        alu_mode <= win_mode;
        rr_ptr   <= ~win;
      end else begin
        alu_mode <= MODE_NOP;
      end
      issue_valid <= hs;
      issue_id    <= win;
      resp_valid  <= issue_valid;
      resp_id     <= issue_id;
    end
  end

  always_comb begin
    lock_owner = 2'b00;
    unique case (state)
      LOCK0:   lock_owner = 2'b01;
      LOCK1:   lock_owner = 2'b10;
      default: lock_owner = 2'b00;
    endcase
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign resp0_valid = resp_valid && !resp_id;
  assign resp1_valid = resp_valid &&  resp_id;
  assign resp_z      = alu_z;

endmodule
